// File: rtl/x25519_input_loader_if.sv
// Byte-frame, core-drive and result signals of the x25519 input loader.
// slave = the loader itself, master = its environment (byte source, core, result sink).
interface x25519_input_loader_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [254:0] sm_k;
    logic [254:0] sm_x_p;
    logic         sm_rst;
    logic [254:0] sm_x_q;
    logic         sm_done;
    logic [254:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic         busy;

    modport slave (
        input  in_data, in_valid, sm_x_q, sm_done, res_ready,
        output in_ready, sm_k, sm_x_p, sm_rst, res_data, res_valid, busy
    );

    modport master (
        output in_data, in_valid, sm_x_q, sm_done, res_ready,
        input  in_ready, sm_k, sm_x_p, sm_rst, res_data, res_valid, busy
    );
endinterface

// File: rtl/x25519_input_loader.sv
// Byte-serial loader for the x25519 scalar_multiplication core: clamps k, masks u and sequences the core.
// Define X25519_LOADER_REDUCE_EN to reduce the masked u modulo 2^255-19 before it reaches the core.
module x25519_input_loader (
    input  logic                  clk,
    input  logic                  rst,
    x25519_input_loader_if.slave  io
);
    typedef enum logic [2:0] {LOAD_K, LOAD_U, REDUCE, RUN, RESULT} state_t;

    state_t       state;
    state_t       state_nx;
    logic [5:0]   cnt;
    logic [255:0] sr;
    logic [255:0] sr_nx;
    logic [253:3] k_buf;
    logic         in_ready_c;
    logic         busy_c;
    logic         xfer;
    logic [254:0] k_clamped;
    logic [254:0] u_masked;
    logic [254:0] u_final;

    assign io.in_ready = in_ready_c;
    assign io.busy     = busy_c;
    assign xfer        = io.in_valid && in_ready_c;

    // Bytes enter at the top and shift down, so byte i ends at bits [8i+7:8i] after 32 shifts.
    assign sr_nx     = {io.in_data, sr[255:8]};
    assign k_clamped = {1'b1, k_buf, 3'b000};
    assign u_masked  = sr[254:0];

`ifdef X25519_LOADER_REDUCE_EN
    localparam logic [254:0] P = {{247{1'b1}}, 8'hED};
    logic [255:0] u_diff;
    // A borrow out of the 256-bit subtraction means u < p.
    assign u_diff  = {1'b0, u_masked} - {1'b0, P};
    assign u_final = u_diff[255] ? u_masked : u_diff[254:0];
`else
    assign u_final = u_masked;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD_K;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        case (state)
            LOAD_K: begin
                in_ready_c = 1'b1;
                if (io.in_valid && cnt == 6'd31) state_nx = LOAD_U;
            end
            LOAD_U: begin
                in_ready_c = 1'b1;
                if (io.in_valid && cnt == 6'd63) state_nx = REDUCE;
            end
            REDUCE: begin
                busy_c   = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (io.sm_done) state_nx = RESULT;
            end
            RESULT: begin
                if (io.res_ready) state_nx = LOAD_K;
            end
            default: state_nx = LOAD_K;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            sr           <= '0;
            k_buf        <= '0;
            io.sm_k      <= '0;
            io.sm_x_p    <= '0;
            io.sm_rst    <= 1'b1;
            io.res_data  <= '0;
            io.res_valid <= 1'b0;
        end else begin
            if (xfer) begin
                cnt <= cnt + 6'd1;
                sr  <= sr_nx;
                if (state == LOAD_K && cnt == 6'd31) k_buf <= sr_nx[253:3];
            end
            case (state)
                REDUCE: begin
                    io.sm_k   <= k_clamped;
                    io.sm_x_p <= u_final;
                    io.sm_rst <= 1'b0;
                end
                RUN: begin
                    if (io.sm_done) begin
                        io.res_data  <= io.sm_x_q;
                        io.res_valid <= 1'b1;
                        io.sm_rst    <= 1'b1;
                    end
                end
                RESULT: begin
                    if (io.res_ready) io.res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_x25519_input_loader.sv
// Directed and randomized bench for x25519_input_loader with an arithmetic clamp/mask/reduce model.
module tb_x25519_input_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    x25519_input_loader_if io();
    x25519_input_loader dut (.clk(clk), .rst(rst), .io(io));

    int tests = 0;
    int fails = 0;
    logic [7:0] frame [64];

    localparam logic [255:0] TWO254 = 256'd1 << 254;
    localparam logic [255:0] TWO255 = 256'd1 << 255;
    localparam logic [255:0] PRIME  = TWO255 - 256'd19;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] le_val(input int base);
        logic [255:0] v = '0;
        for (int i = 0; i < 32; i++) v = v + ({248'd0, frame[base + i]} << (8 * i));
        return v;
    endfunction

    function automatic logic [255:0] model_k();
        logic [255:0] v = le_val(0) % TWO255;
        v = v - (v % 256'd8);
        if (((v / TWO254) % 256'd2) == 256'd0) v = v + TWO254;
        return v;
    endfunction

    function automatic logic [255:0] model_u();
        logic [255:0] v = le_val(32) % TWO255;
`ifdef X25519_LOADER_REDUCE_EN
        if (v >= PRIME) v = v - PRIME;
`endif
        return v;
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | {224'd0, $urandom};
        return v[254:0];
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);
        if ($urandom_range(2, 0) == 0) for (int i = 33; i < 64; i++) frame[i] = 8'hFF;
    endtask

    // Offers nbytes frame bytes, interleaving idle cycles carrying junk data when gaps is set.
    task automatic send_bytes(input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            bit accepted = 1'b0;
            int tries = 0;
            while (!accepted) begin
                logic rdy;
                if (gaps && tries < 6 && $urandom_range(1, 0) == 1) begin
                    io.in_valid = 1'b0;
                    io.in_data  = 8'($urandom);
                end else begin
                    io.in_valid = 1'b1;
                    io.in_data  = frame[i];
                end
                rdy = io.in_ready;
                if (io.in_valid) check("in_ready_load", {255'd0, rdy}, 256'd1);
                tick();
                accepted = io.in_valid && rdy;
                tries++;
            end
        end
        io.in_valid = 1'b0;
    endtask

    task automatic expect_reduce();
        check("busy_reduce", {255'd0, io.busy}, 256'd1);
        check("in_ready_reduce", {255'd0, io.in_ready}, 256'd0);
        check("sm_rst_reduce", {255'd0, io.sm_rst}, 256'd1);
        tick();
        check("sm_rst_run", {255'd0, io.sm_rst}, 256'd0);
        check("sm_k", {1'b0, io.sm_k}, model_k());
        check("sm_x_p", {1'b0, io.sm_x_p}, model_u());
    endtask

    // Core model: runs for the given cycles, strobes done, then the sink stalls for hold cycles.
    task automatic run_core(input logic [254:0] result, input int cycles, input int hold);
        for (int c = 0; c < cycles; c++) begin
            io.in_valid = 1'($urandom);
            io.in_data  = 8'($urandom);
            check("busy_run", {255'd0, io.busy}, 256'd1);
            check("sm_rst_low", {255'd0, io.sm_rst}, 256'd0);
            tick();
        end
        io.in_valid = 1'b0;
        io.sm_done  = 1'b1;
        io.sm_x_q   = result;
        tick();
        io.sm_done  = 1'b0;
        io.sm_x_q   = rand255();
        check("res_valid_set", {255'd0, io.res_valid}, 256'd1);
        check("res_data", {1'b0, io.res_data}, {1'b0, result});
        check("sm_rst_park", {255'd0, io.sm_rst}, 256'd1);
        check("busy_result", {255'd0, io.busy}, 256'd0);
        check("in_ready_result", {255'd0, io.in_ready}, 256'd0);
        for (int h = 1; h < hold; h++) begin
            io.in_valid = 1'($urandom);
            tick();
            check("res_valid_hold", {255'd0, io.res_valid}, 256'd1);
        end
        io.in_valid  = 1'b0;
        io.res_ready = 1'b1;
        tick();
        io.res_ready = 1'b0;
        check("res_valid_clear", {255'd0, io.res_valid}, 256'd0);
        check("in_ready_after", {255'd0, io.in_ready}, 256'd1);
        check("res_data_held", {1'b0, io.res_data}, {1'b0, result});
        check("sm_k_stable", {1'b0, io.sm_k}, model_k());
    endtask

    task automatic full_frame(input bit gaps, input int cycles, input int hold);
        send_bytes(64, gaps);
        expect_reduce();
        run_core(rand255(), cycles, hold);
    endtask

    initial begin
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.sm_done = 1'b0;
        io.sm_x_q = '0;
        io.res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {255'd0, io.in_ready}, 256'd1);
        check("rst_busy", {255'd0, io.busy}, 256'd0);
        check("rst_sm_rst", {255'd0, io.sm_rst}, 256'd1);
        check("rst_sm_k", {1'b0, io.sm_k}, 256'd0);
        check("rst_sm_x_p", {1'b0, io.sm_x_p}, 256'd0);
        check("rst_res_data", {1'b0, io.res_data}, 256'd0);
        check("rst_res_valid", {255'd0, io.res_valid}, 256'd0);

        // sm_done outside RUN must be ignored
        io.sm_done = 1'b1;
        io.sm_x_q  = rand255();
        tick();
        io.sm_done = 1'b0;
        check("done_ignored_valid", {255'd0, io.res_valid}, 256'd0);
        check("done_ignored_ready", {255'd0, io.in_ready}, 256'd1);

        // Scalar all 0xFF, u = 32
        for (int i = 0; i < 64; i++) frame[i] = (i < 32) ? 8'hFF : 8'h00;
        frame[32] = 8'h20;
        send_bytes(64, 1'b0);
        expect_reduce();
        check("sm_k_ff_const", {1'b0, io.sm_k}, TWO255 - 256'd8);
        check("sm_x_p_32_const", {1'b0, io.sm_x_p}, 256'd32);
        run_core(255'h1234, 20, 5);

        // Scalar 0, u all 0xFF
        for (int i = 0; i < 64; i++) frame[i] = (i < 32) ? 8'h00 : 8'hFF;
        send_bytes(64, 1'b1);
        expect_reduce();
        check("sm_k_zero_const", {1'b0, io.sm_k}, TWO254);
        run_core(rand255(), 3, 1);

        // u = p exactly
        for (int i = 0; i < 32; i++) frame[i] = 8'($urandom);
        frame[32] = 8'hED;
        for (int i = 33; i < 63; i++) frame[i] = 8'hFF;
        frame[63] = 8'h7F;
        send_bytes(64, 1'b1);
        expect_reduce();
        run_core(rand255(), 2, 2);

        for (int f = 0; f < 6; f++) begin
            rand_frame();
            full_frame(1'b1, $urandom_range(8, 1), $urandom_range(4, 1));
        end

        // Reset after byte 40 discards the partial frame
        rand_frame();
        send_bytes(41, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midframe_rst_in_ready", {255'd0, io.in_ready}, 256'd1);
        check("midframe_rst_sm_rst", {255'd0, io.sm_rst}, 256'd1);
        check("midframe_rst_res_valid", {255'd0, io.res_valid}, 256'd0);
        check("midframe_rst_sm_k", {1'b0, io.sm_k}, 256'd0);
        rand_frame();
        full_frame(1'b1, 4, 2);

        // Reset in the middle of RUN aborts the core
        rand_frame();
        send_bytes(64, 1'b0);
        expect_reduce();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("run_rst_sm_rst", {255'd0, io.sm_rst}, 256'd1);
        check("run_rst_busy", {255'd0, io.busy}, 256'd0);
        check("run_rst_in_ready", {255'd0, io.in_ready}, 256'd1);
        check("run_rst_res_valid", {255'd0, io.res_valid}, 256'd0);
        rand_frame();
        full_frame(1'b1, 5, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
